// File: rtl/predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : predictor_pkg
// Description : Shared types and helpers for the local-history predictor.
//               Holds the init/run state encoding and the saturating-counter
//               helpers. The helpers take the counter width as an argument
//               and work on 32-bit values; callers truncate to their width.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package predictor_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Largest value representable in a w-bit counter.
    function automatic logic [31:0] ctr_max(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = ctr_max(w);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v, input int unsigned w);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    // Weakly not-taken: the largest value whose MSB is still 0.
    function automatic logic [31:0] weak_nt(input int unsigned w);
        return 32'((64'd1 << (w - 1)) - 64'd1);
    endfunction

endpackage : predictor_pkg
`default_nettype wire

// File: rtl/predictor_row.sv
`default_nettype none
// ============================================================================
// Module      : predictor_row
// Description : One predictor row of 2**HIST_W saturating counters.
//               clear rewrites every column to weakly-not-taken and takes
//               priority over a same-cycle update. Counters carry no reset;
//               the owner initialises them by sweeping clear.
// Ports       : clk       - clock
//               clear     - rewrite all columns to weakly-not-taken
//               upd_en    - apply a saturating step to column upd_col
//               upd_col   - column to update
//               upd_taken - 1 increments, 0 decrements
//               ctrs      - all counters, column c at [c*CTR_W +: CTR_W]
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module predictor_row
    import predictor_pkg::*;
#(
    parameter int HIST_W = 3,
    parameter int CTR_W  = 2
) (
    input  logic                           clk,
    input  logic                           clear,
    input  logic                           upd_en,
    input  logic [HIST_W-1:0]              upd_col,
    input  logic                           upd_taken,
    output logic [(2**HIST_W)*CTR_W-1:0]   ctrs
);

    localparam int               c_COLS    = 2**HIST_W;
    localparam logic [CTR_W-1:0] c_WEAK_NT = CTR_W'(weak_nt(CTR_W));

    logic [c_COLS-1:0][CTR_W-1:0] r_ctr;
    logic [CTR_W-1:0]             w_next;

    always_comb begin
        w_next = r_ctr[upd_col];
        if (upd_taken) begin
            w_next = CTR_W'(sat_inc(32'(r_ctr[upd_col]), CTR_W));
        end else begin
            w_next = CTR_W'(sat_dec(32'(r_ctr[upd_col]), CTR_W));
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_ctr <= {c_COLS{c_WEAK_NT}};
        end else if (upd_en) begin
            r_ctr[upd_col] <= w_next;
        end
    end

    assign ctrs = r_ctr;

endmodule : predictor_row
`default_nettype wire

// File: rtl/local_history_predictor.sv
`default_nettype none
// ============================================================================
// Module      : local_history_predictor
// Description : Local-history branch predictor. Rows of saturating counters
//               are selected by PC low bits, columns by branch history.
//               After rst an INIT sweep writes every row to weakly-not-taken,
//               then ready rises. Lookups have one cycle of latency with a
//               write-first bypass of same-cycle evicts/updates.
//               Optional statistics: define PREDICTOR_STATS_EN.
// Ports       : clk, rst                 - clock, sync active-high reset
//               lk_valid/lk_pc/lk_hist   - lookup request
//               pred_valid/taken/ctr     - registered lookup result
//               upd_valid/pc/hist/taken  - resolved-branch update
//               evict/evict_pc           - reinitialise one row
//               ready                    - table initialised
//               stat_updates/mispred     - statistics (0 unless enabled)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module local_history_predictor
    import predictor_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int IDX_W  = 4,
    parameter int HIST_W = 3,
    parameter int CTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lk_valid,
    input  logic [PC_W-1:0]   lk_pc,
    input  logic [HIST_W-1:0] lk_hist,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [CTR_W-1:0]  pred_ctr,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    input  logic              evict,
    input  logic [PC_W-1:0]   evict_pc,
    output logic              ready,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispred
);

    localparam int               c_ROWS    = 2**IDX_W;
    localparam int               c_COLS    = 2**HIST_W;
    localparam logic [CTR_W-1:0] c_WEAK_NT = CTR_W'(weak_nt(CTR_W));
    localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(c_ROWS - 1);

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_sweep_row, w_sweep_next;
    logic             r_ready;
    logic             r_pred_valid, r_pred_taken;
    logic [CTR_W-1:0] r_pred_ctr;

    logic [IDX_W-1:0] w_lk_row, w_upd_row, w_evict_row;
    logic             w_sweeping, w_upd_ok, w_evict_ok, w_upd_apply;
    logic [CTR_W-1:0] w_upd_old, w_upd_new, w_lk_stored, w_lk_value;
    logic [c_ROWS-1:0] w_clear, w_upd_en;
    logic [c_ROWS-1:0][c_COLS*CTR_W-1:0] w_row_ctrs;
    logic             w_unused_pc_hi;

    assign w_lk_row    = lk_pc[IDX_W-1:0];
    assign w_upd_row   = upd_pc[IDX_W-1:0];
    assign w_evict_row = evict_pc[IDX_W-1:0];
    // Tag-less table: the upper PC bits are deliberately ignored (aliasing).
    assign w_unused_pc_hi = &{lk_pc[PC_W-1:IDX_W], upd_pc[PC_W-1:IDX_W],
                              evict_pc[PC_W-1:IDX_W]};

    // Traffic is accepted only once ready is visible and not under reset,
    // so nothing leaks in during the cycle the FSM flips to RUN.
    assign w_sweeping  = (r_state == ST_INIT) && !rst;
    assign w_evict_ok  = evict && r_ready && !rst;
    assign w_upd_ok    = upd_valid && r_ready && !rst;
    // An evict of the same row wins and discards the update.
    assign w_upd_apply = w_upd_ok && !(w_evict_ok && (w_evict_row == w_upd_row));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_sweep_row <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sweep_row <= w_sweep_next;
            r_ready     <= (r_state == ST_RUN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sweep_next = r_sweep_row;
        case (r_state)
            ST_INIT: begin
                w_sweep_next = r_sweep_row + 1'b1;
                if (r_sweep_row == c_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    // ------------------------------------------------------- row controls
    always_comb begin
        w_clear  = '0;
        w_upd_en = '0;
        for (int i = 0; i < c_ROWS; i++) begin
            w_clear[i]  = (w_sweeping && (r_sweep_row == IDX_W'(i))) ||
                          (w_evict_ok && (w_evict_row == IDX_W'(i)));
            w_upd_en[i] = w_upd_apply && (w_upd_row == IDX_W'(i));
        end
    end

    for (genvar gi = 0; gi < c_ROWS; gi++) begin : g_rows
        predictor_row #(
            .HIST_W (HIST_W),
            .CTR_W  (CTR_W)
        ) u_row (
            .clk       (clk),
            .clear     (w_clear[gi]),
            .upd_en    (w_upd_en[gi]),
            .upd_col   (upd_hist),
            .upd_taken (upd_taken),
            .ctrs      (w_row_ctrs[gi])
        );
    end

    // ---------------------------------------------- lookup with bypass
    always_comb begin
        w_upd_old   = w_row_ctrs[w_upd_row][upd_hist*CTR_W +: CTR_W];
        w_upd_new   = upd_taken ? CTR_W'(sat_inc(32'(w_upd_old), CTR_W))
                                : CTR_W'(sat_dec(32'(w_upd_old), CTR_W));
        w_lk_stored = w_row_ctrs[w_lk_row][lk_hist*CTR_W +: CTR_W];
        w_lk_value  = w_lk_stored;
        if (w_evict_ok && (w_evict_row == w_lk_row)) begin
            w_lk_value = c_WEAK_NT;
        end else if (w_upd_apply && (w_upd_row == w_lk_row) && (upd_hist == lk_hist)) begin
            w_lk_value = w_upd_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_ctr   <= '0;
        end else begin
            r_pred_valid <= lk_valid && r_ready;
            if (lk_valid && r_ready) begin
                r_pred_ctr   <= w_lk_value;
                r_pred_taken <= w_lk_value[CTR_W-1];
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_ctr   = r_pred_ctr;
    assign ready      = r_ready;

    // ------------------------------------------------------- statistics
`ifdef PREDICTOR_STATS_EN
    logic [31:0] r_stat_updates, r_stat_mispred;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_updates <= '0;
            r_stat_mispred <= '0;
        end else if (w_upd_apply) begin
            r_stat_updates <= r_stat_updates + 32'd1;
            if (w_upd_old[CTR_W-1] != upd_taken) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign stat_updates = r_stat_updates;
    assign stat_mispred = r_stat_mispred;
`else
    assign stat_updates = '0;
    assign stat_mispred = '0;
`endif

endmodule : local_history_predictor
`default_nettype wire

// File: tb/tb_local_history_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_local_history_predictor
// Description : Directed self-checking bench for local_history_predictor
//               with default parameters. Expected values are hand-derived.
//               Build with PREDICTOR_STATS_EN to exercise the statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_local_history_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        lk_valid;
    logic [9:0]  lk_pc;
    logic [2:0]  lk_hist;
    logic        pred_valid, pred_taken;
    logic [1:0]  pred_ctr;
    logic        upd_valid;
    logic [9:0]  upd_pc;
    logic [2:0]  upd_hist;
    logic        upd_taken;
    logic        evict;
    logic [9:0]  evict_pc;
    logic        ready;
    logic [31:0] stat_updates, stat_mispred;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    local_history_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .lk_valid     (lk_valid),
        .lk_pc        (lk_pc),
        .lk_hist      (lk_hist),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_ctr     (pred_ctr),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_hist     (upd_hist),
        .upd_taken    (upd_taken),
        .evict        (evict),
        .evict_pc     (evict_pc),
        .ready        (ready),
        .stat_updates (stat_updates),
        .stat_mispred (stat_mispred)
    );

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic lookup(input logic [9:0] pc, input logic [2:0] h);
        lk_valid = 1'b1; lk_pc = pc; lk_hist = h;
        step();
        lk_valid = 1'b0;
    endtask

    task automatic update(input logic [9:0] pc, input logic [2:0] h, input logic t);
        upd_valid = 1'b1; upd_pc = pc; upd_hist = h; upd_taken = t;
        step();
        upd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lk_valid = 1'b0; lk_pc = '0; lk_hist = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_hist = '0; upd_taken = 1'b0;
        evict = 1'b0; evict_pc = '0;
        step(); step();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_pvalid", 32'(pred_valid), 0);
        chk("rst_ctr", 32'(pred_ctr), 0);
        chk("rst_taken", 32'(pred_taken), 0);
        chk("rst_stat_upd", stat_updates, 0);
        chk("rst_stat_mis", stat_mispred, 0);

        // Init sweep: 16 row writes, ready visible on the 17th edge.
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("sweep_ready_%0d", k), 32'(ready), 0);
        end
        step();
        chk("sweep_ready_17", 32'(ready), 1);

        lookup(10'h005, 3'd3);
        chk("init_pvalid", 32'(pred_valid), 1);
        chk("init_ctr", 32'(pred_ctr), 1);
        chk("init_taken", 32'(pred_taken), 0);
        step();
        chk("idle_pvalid", 32'(pred_valid), 0);
        chk("idle_ctr_hold", 32'(pred_ctr), 1);

        // Saturation up and down.
        for (int k = 0; k < 3; k++) update(10'h005, 3'd3, 1'b1);
        lookup(10'h005, 3'd3);
        chk("sat_hi_ctr", 32'(pred_ctr), 3);
        chk("sat_hi_taken", 32'(pred_taken), 1);
        for (int k = 0; k < 5; k++) update(10'h005, 3'd3, 1'b0);
        lookup(10'h005, 3'd3);
        chk("sat_lo_ctr", 32'(pred_ctr), 0);
        update(10'h005, 3'd3, 1'b0);
        lookup(10'h005, 3'd3);
        chk("sat_lo_stay", 32'(pred_ctr), 0);
        chk("sat_lo_taken", 32'(pred_taken), 0);

        // Bypass: counter at 1, same-cycle taken update and lookup.
        update(10'h005, 3'd3, 1'b1);
        upd_valid = 1'b1; upd_pc = 10'h005; upd_hist = 3'd3; upd_taken = 1'b1;
        lk_valid = 1'b1; lk_pc = 10'h005; lk_hist = 3'd3;
        step();
        upd_valid = 1'b0; lk_valid = 1'b0;
        chk("byp_ctr", 32'(pred_ctr), 2);
        chk("byp_taken", 32'(pred_taken), 1);
        lookup(10'h005, 3'd3);
        chk("byp_stored", 32'(pred_ctr), 2);

        // Evict priority: row 5 col 3 at 3, row 6 col 3 at 2.
        update(10'h005, 3'd3, 1'b1);
        update(10'h006, 3'd3, 1'b1);
        evict = 1'b1; evict_pc = 10'h015;
        upd_valid = 1'b1; upd_pc = 10'h005; upd_hist = 3'd3; upd_taken = 1'b1;
        lk_valid = 1'b1; lk_pc = 10'h005; lk_hist = 3'd3;
        step();
        evict = 1'b0; upd_valid = 1'b0; lk_valid = 1'b0;
        chk("evict_byp_ctr", 32'(pred_ctr), 1);
        lookup(10'h005, 3'd3);
        chk("evict_stored", 32'(pred_ctr), 1);
        lookup(10'h006, 3'd3);
        chk("evict_row6_kept", 32'(pred_ctr), 2);
        lookup(10'h105, 3'd3);
        chk("alias_row5", 32'(pred_ctr), 1);

        // Evict and update on different rows both apply.
        evict = 1'b1; evict_pc = 10'h006;
        upd_valid = 1'b1; upd_pc = 10'h005; upd_hist = 3'd3; upd_taken = 1'b1;
        step();
        evict = 1'b0; upd_valid = 1'b0;
        lookup(10'h005, 3'd3);
        chk("diff_row_upd", 32'(pred_ctr), 2);
        lookup(10'h006, 3'd3);
        chk("diff_row_evict", 32'(pred_ctr), 1);

        // Reset mid-sweep, then a full sweep with traffic that must be ignored.
        update(10'h009, 3'd3, 1'b1);
        update(10'h009, 3'd3, 1'b1);
        lookup(10'h009, 3'd3);
        chk("row9_pre", 32'(pred_ctr), 3);
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        chk("mid_ready", 32'(ready), 0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_ready", 32'(ready), 0);
        lk_valid = 1'b1; lk_pc = 10'h009; lk_hist = 3'd3;
        upd_valid = 1'b1; upd_pc = 10'h00F; upd_hist = 3'd3; upd_taken = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("resweep_ready_%0d", k), 32'(ready), 0);
            chk($sformatf("resweep_pvalid_%0d", k), 32'(pred_valid), 0);
        end
        step();
        upd_valid = 1'b0; lk_valid = 1'b0;
        chk("resweep_ready_17", 32'(ready), 1);
        chk("resweep_pvalid_17", 32'(pred_valid), 0);
        lookup(10'h009, 3'd3);
        chk("row9_swept", 32'(pred_ctr), 1);
        lookup(10'h00F, 3'd3);
        chk("row15_no_upd", 32'(pred_ctr), 1);

        // Statistics: counter 1 -> T(mis) 2 -> T 3 -> N(mis) 2 -> T 3.
        update(10'h003, 3'd0, 1'b1);
        update(10'h003, 3'd0, 1'b1);
        update(10'h003, 3'd0, 1'b0);
        update(10'h003, 3'd0, 1'b1);
        lookup(10'h003, 3'd0);
        chk("stat_seq_ctr", 32'(pred_ctr), 3);
`ifdef PREDICTOR_STATS_EN
        chk("stat_updates", stat_updates, 4);
        chk("stat_mispred", stat_mispred, 2);
`else
        chk("stat_updates_off", stat_updates, 0);
        chk("stat_mispred_off", stat_mispred, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_local_history_predictor
`default_nettype wire
